b_all_frame_er_ctrl: RTL and testbench

Bob-side all-frame error-reconciliation sequencer. It is the counterpart of Alice's all-frame controller on the other end of the ER FIFO link. It walks frame rounds 0..MAX_FRAME_ROUND and launches Bob's single-frame ER engine once per frame. It accumulates per-frame leaked-info, error-count and verification-fail reports into run totals, optionally aborts the run on the first failed frame, and signals completion to the post-processing top level.

---
 rtl/er_all_frame_pkg.sv | 26 ++
 rtl/b_all_frame_er_ctrl_if.sv | 49 ++++
 rtl/b_all_frame_fsm.sv | 72 +++++++
 rtl/b_all_frame_er_ctrl.sv | 135 +++++++++++++
 tb/tb_b_all_frame_er_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/er_all_frame_pkg.sv
// ---------------------------------------------------------------------------
// er_all_frame_pkg
// Shared definitions for the all-frame error-reconciliation controllers.
// Both Alice's and Bob's sequencers use these state codes, so the 4-bit
// values must stay fixed. The default widths below are used by the Bob-side
// controller and its single-frame handshake interface.
// ---------------------------------------------------------------------------
package er_all_frame_pkg;

    localparam int AF_STATE_W = 4;

    localparam logic [AF_STATE_W-1:0] ST_IDLE         = 4'd0;
    localparam logic [AF_STATE_W-1:0] ST_START_AF_ER  = 4'd1;
    localparam logic [AF_STATE_W-1:0] ST_START_SF_ER  = 4'd2;
    localparam logic [AF_STATE_W-1:0] ST_SF_ER_BUSY   = 4'd3;
    localparam logic [AF_STATE_W-1:0] ST_FINISH_SF_ER = 4'd4;
    localparam logic [AF_STATE_W-1:0] ST_RESET_AF_ER  = 4'd5;
    localparam logic [AF_STATE_W-1:0] ST_AF_ER_END    = 4'd6;

    localparam int DEF_MAX_FRAME_ROUND   = 7;
    localparam int DEF_FRAME_ROUND_WIDTH = 3;
    localparam int DEF_LEAKED_WIDTH      = 16;
    localparam int DEF_ERRCNT_WIDTH      = 16;
    localparam int DEF_TOTAL_WIDTH       = 24;

endpackage

// File: rtl/b_all_frame_er_ctrl_if.sv
// ---------------------------------------------------------------------------
// b_all_frame_er_ctrl_if
// Handshake between Bob's all-frame sequencer (master) and Bob's single-frame
// ER engine (slave).
//   start_single_frame_ER      master->slave  one-cycle frame start pulse
//   frame_round                master->slave  index of the frame to process
//   finish_B_single_frame_ER   slave->master  one-cycle frame done pulse
//   sf_leaked_info             slave->master  leaked-info report
//   sf_error_count             slave->master  error-count report
//   sf_parameter_valid         slave->master  qualifies the two reports
//   sf_error_verification_fail slave->master  valid with the done pulse
// ---------------------------------------------------------------------------
interface b_all_frame_er_ctrl_if
    import er_all_frame_pkg::*;
#(
    parameter int FRAME_ROUND_WIDTH = DEF_FRAME_ROUND_WIDTH,
    parameter int LEAKED_WIDTH      = DEF_LEAKED_WIDTH,
    parameter int ERRCNT_WIDTH      = DEF_ERRCNT_WIDTH
);

    logic                         start_single_frame_ER;
    logic [FRAME_ROUND_WIDTH-1:0] frame_round;
    logic                         finish_B_single_frame_ER;
    logic [LEAKED_WIDTH-1:0]      sf_leaked_info;
    logic [ERRCNT_WIDTH-1:0]      sf_error_count;
    logic                         sf_parameter_valid;
    logic                         sf_error_verification_fail;

    modport master (
        output start_single_frame_ER,
        output frame_round,
        input  finish_B_single_frame_ER,
        input  sf_leaked_info,
        input  sf_error_count,
        input  sf_parameter_valid,
        input  sf_error_verification_fail
    );

    modport slave (
        input  start_single_frame_ER,
        input  frame_round,
        output finish_B_single_frame_ER,
        output sf_leaked_info,
        output sf_error_count,
        output sf_parameter_valid,
        output sf_error_verification_fail
    );

endinterface

// File: rtl/b_all_frame_fsm.sv
// ---------------------------------------------------------------------------
// b_all_frame_fsm
// State register, next-state logic and Moore outputs of Bob's all-frame
// sequencer. The datapath (frame counter, accumulators) lives in the parent.
//   clk, rst_n     clock, synchronous active-low reset
//   start_i        run start request (honoured only in IDLE)
//   sf_finish_i    single-frame done pulse
//   end_run_i      the frame finishing now is the last one of the run
//   state_o        current state code
//   start_sf_o     start pulse to the single-frame engine
//   finish_af_o    run-done pulse
//   busy_o         any state but IDLE
//   clear_run_o    clear totals and fail status (START_AF_ER)
//   clear_frame_o  clear frame_round (RESET_AF_ER)
//   sf_busy_o      waiting on the single-frame engine (SF_ER_BUSY)
//   adv_frame_o    advance frame_round this cycle
// ---------------------------------------------------------------------------
module b_all_frame_fsm
    import er_all_frame_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic                  sf_finish_i,
    input  logic                  end_run_i,
    output logic [AF_STATE_W-1:0] state_o,
    output logic                  start_sf_o,
    output logic                  finish_af_o,
    output logic                  busy_o,
    output logic                  clear_run_o,
    output logic                  clear_frame_o,
    output logic                  sf_busy_o,
    output logic                  adv_frame_o
);

    logic [AF_STATE_W-1:0] state_q, state_d;

    // NOTE: combinational blocks use blocking '=' and assign a default first,
    // so every path drives state_d and no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:         if (start_i) state_d = ST_START_AF_ER;
            ST_START_AF_ER:  state_d = ST_START_SF_ER;
            ST_START_SF_ER:  state_d = ST_SF_ER_BUSY;
            ST_SF_ER_BUSY: begin
                if (sf_finish_i) state_d = end_run_i ? ST_RESET_AF_ER : ST_FINISH_SF_ER;
            end
            ST_FINISH_SF_ER: state_d = ST_START_SF_ER;
            ST_RESET_AF_ER:  state_d = ST_AF_ER_END;
            ST_AF_ER_END:    state_d = ST_IDLE;
            default:         state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking '<='; reset is synchronous,
    // so rst_n is only looked at on the clock edge.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    assign state_o       = state_q;
    assign start_sf_o    = (state_q == ST_START_SF_ER);
    assign finish_af_o   = (state_q == ST_AF_ER_END);
    assign busy_o        = (state_q != ST_IDLE);
    assign clear_run_o   = (state_q == ST_START_AF_ER);
    assign clear_frame_o = (state_q == ST_RESET_AF_ER);
    assign sf_busy_o     = (state_q == ST_SF_ER_BUSY);
    assign adv_frame_o   = (state_q == ST_SF_ER_BUSY) && sf_finish_i && !end_run_i;

endmodule

// File: rtl/b_all_frame_er_ctrl.sv
// ---------------------------------------------------------------------------
// b_all_frame_er_ctrl
// Bob-side all-frame ER sequencer. Runs frames 0..MAX_FRAME_ROUND through the
// single-frame ER engine, accumulates saturating run totals of leaked info
// and error count, counts verification failures, optionally aborts on the
// first failed frame and pulses finish_all_frame_ER when the run ends.
//   clk, rst_n            clock, synchronous active-low reset
//   start_B_all_frame_ER  run start pulse (IDLE only)
//   sf_if                 master side of the single-frame ER handshake
//   total_leaked_info     saturating run sum of leaked info
//   total_error_count     saturating run sum of error counts
//   failed_frame_count    frames that failed verification this run
//   all_frame_fail        any frame failed this run
//   finish_all_frame_ER   one-cycle run-done pulse
//   busy                  controller not in IDLE
//   B_all_frame_state     current FSM state code
// ---------------------------------------------------------------------------
module b_all_frame_er_ctrl
    import er_all_frame_pkg::*;
#(
    parameter int MAX_FRAME_ROUND   = DEF_MAX_FRAME_ROUND,
    parameter int FRAME_ROUND_WIDTH = DEF_FRAME_ROUND_WIDTH,
    parameter int LEAKED_WIDTH      = DEF_LEAKED_WIDTH,
    parameter int ERRCNT_WIDTH      = DEF_ERRCNT_WIDTH,
    parameter int TOTAL_WIDTH       = DEF_TOTAL_WIDTH,
    parameter bit ABORT_ON_FAIL     = 1'b0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start_B_all_frame_ER,
    b_all_frame_er_ctrl_if.master        sf_if,
    output logic [TOTAL_WIDTH-1:0]       total_leaked_info,
    output logic [TOTAL_WIDTH-1:0]       total_error_count,
    output logic [FRAME_ROUND_WIDTH:0]   failed_frame_count,
    output logic                         all_frame_fail,
    output logic                         finish_all_frame_ER,
    output logic                         busy,
    output logic [AF_STATE_W-1:0]        B_all_frame_state
);

    // Sums are formed one bit wider than the larger operand so that an
    // overflow past the total's maximum is visible and can be clamped, even
    // when a report is wider than the total.
    localparam int LSUM_W = ((LEAKED_WIDTH > TOTAL_WIDTH) ? LEAKED_WIDTH : TOTAL_WIDTH) + 1;
    localparam int ESUM_W = ((ERRCNT_WIDTH > TOTAL_WIDTH) ? ERRCNT_WIDTH : TOTAL_WIDTH) + 1;
    localparam logic [TOTAL_WIDTH-1:0] TOTAL_MAX = '1;

    logic [FRAME_ROUND_WIDTH-1:0] frame_round_q, frame_round_d;
    logic [TOTAL_WIDTH-1:0]       total_leaked_q, total_leaked_d;
    logic [TOTAL_WIDTH-1:0]       total_err_q, total_err_d;
    logic [FRAME_ROUND_WIDTH:0]   fail_cnt_q, fail_cnt_d;
    logic                         any_fail_q, any_fail_d;

    logic clear_run, clear_frame, sf_busy, adv_frame, end_run, frame_fail;
    logic [LSUM_W-1:0] leaked_sum;
    logic [ESUM_W-1:0] err_sum;

    // A run ends on the last frame, or early on a failed frame when aborting.
    assign end_run = (frame_round_q == FRAME_ROUND_WIDTH'(MAX_FRAME_ROUND))
                  || (ABORT_ON_FAIL && sf_if.sf_error_verification_fail);

    b_all_frame_fsm u_fsm (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_i       (start_B_all_frame_ER),
        .sf_finish_i   (sf_if.finish_B_single_frame_ER),
        .end_run_i     (end_run),
        .state_o       (B_all_frame_state),
        .start_sf_o    (sf_if.start_single_frame_ER),
        .finish_af_o   (finish_all_frame_ER),
        .busy_o        (busy),
        .clear_run_o   (clear_run),
        .clear_frame_o (clear_frame),
        .sf_busy_o     (sf_busy),
        .adv_frame_o   (adv_frame)
    );

    assign frame_fail = sf_busy && sf_if.finish_B_single_frame_ER
                                && sf_if.sf_error_verification_fail;

    assign leaked_sum = LSUM_W'(total_leaked_q) + LSUM_W'(sf_if.sf_leaked_info);
    assign err_sum    = ESUM_W'(total_err_q)    + ESUM_W'(sf_if.sf_error_count);

    always_comb begin
        frame_round_d  = frame_round_q;
        total_leaked_d = total_leaked_q;
        total_err_d    = total_err_q;
        fail_cnt_d     = fail_cnt_q;
        any_fail_d     = any_fail_q;

        if (clear_frame)    frame_round_d = '0;
        else if (adv_frame) frame_round_d = frame_round_q + 1'b1;

        if (clear_run) begin
            total_leaked_d = '0;
            total_err_d    = '0;
            fail_cnt_d     = '0;
            any_fail_d     = 1'b0;
        end else begin
            if (sf_busy && sf_if.sf_parameter_valid) begin
                total_leaked_d = (leaked_sum > LSUM_W'(TOTAL_MAX)) ? TOTAL_MAX
                                                                   : leaked_sum[TOTAL_WIDTH-1:0];
                total_err_d    = (err_sum > ESUM_W'(TOTAL_MAX)) ? TOTAL_MAX
                                                                : err_sum[TOTAL_WIDTH-1:0];
            end
            if (frame_fail) begin
                fail_cnt_d = fail_cnt_q + 1'b1;
                any_fail_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_round_q  <= '0;
            total_leaked_q <= '0;
            total_err_q    <= '0;
            fail_cnt_q     <= '0;
            any_fail_q     <= 1'b0;
        end else begin
            frame_round_q  <= frame_round_d;
            total_leaked_q <= total_leaked_d;
            total_err_q    <= total_err_d;
            fail_cnt_q     <= fail_cnt_d;
            any_fail_q     <= any_fail_d;
        end
    end

    assign sf_if.frame_round = frame_round_q;
    assign total_leaked_info  = total_leaked_q;
    assign total_error_count  = total_err_q;
    assign failed_frame_count = fail_cnt_q;
    assign all_frame_fail     = any_fail_q;

endmodule

// File: tb/tb_b_all_frame_er_ctrl.sv
// ---------------------------------------------------------------------------
// tb_b_all_frame_er_ctrl
// Three controllers with MAX_FRAME_ROUND=3: dut_a (no abort, 24-bit totals),
// dut_b (abort on fail), dut_c (8-bit totals). The bench plays the
// single-frame engine for whichever controller 'sel' points at; the others
// see idle inputs.
// ---------------------------------------------------------------------------
module tb_b_all_frame_er_ctrl;
    import er_all_frame_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [1:0]  sel;
    logic        start_drv, finish_drv, valid_drv, fail_drv;
    logic [15:0] leaked_drv, err_drv;

    int cyc = 0, n_start = 0, n_fin = 0;
    int n_cmp = 0, n_bad = 0;

    b_all_frame_er_ctrl_if #(.FRAME_ROUND_WIDTH(3), .LEAKED_WIDTH(16), .ERRCNT_WIDTH(16)) if_a ();
    b_all_frame_er_ctrl_if #(.FRAME_ROUND_WIDTH(3), .LEAKED_WIDTH(16), .ERRCNT_WIDTH(16)) if_b ();
    b_all_frame_er_ctrl_if #(.FRAME_ROUND_WIDTH(3), .LEAKED_WIDTH(16), .ERRCNT_WIDTH(16)) if_c ();

    assign if_a.finish_B_single_frame_ER   = finish_drv && (sel == 2'd0);
    assign if_a.sf_parameter_valid         = valid_drv  && (sel == 2'd0);
    assign if_a.sf_error_verification_fail = fail_drv;
    assign if_a.sf_leaked_info             = leaked_drv;
    assign if_a.sf_error_count             = err_drv;
    assign if_b.finish_B_single_frame_ER   = finish_drv && (sel == 2'd1);
    assign if_b.sf_parameter_valid         = valid_drv  && (sel == 2'd1);
    assign if_b.sf_error_verification_fail = fail_drv;
    assign if_b.sf_leaked_info             = leaked_drv;
    assign if_b.sf_error_count             = err_drv;
    assign if_c.finish_B_single_frame_ER   = finish_drv && (sel == 2'd2);
    assign if_c.sf_parameter_valid         = valid_drv  && (sel == 2'd2);
    assign if_c.sf_error_verification_fail = fail_drv;
    assign if_c.sf_leaked_info             = leaked_drv;
    assign if_c.sf_error_count             = err_drv;

    logic [23:0] tl_a, te_a, tl_b, te_b;
    logic [7:0]  tl_c, te_c;
    logic [3:0]  ffc_a, ffc_b, ffc_c, st_a, st_b, st_c;
    logic        aff_a, aff_b, aff_c, fin_a, fin_b, fin_c, busy_a, busy_b, busy_c;

    b_all_frame_er_ctrl #(.MAX_FRAME_ROUND(3), .FRAME_ROUND_WIDTH(3), .LEAKED_WIDTH(16),
                          .ERRCNT_WIDTH(16), .TOTAL_WIDTH(24), .ABORT_ON_FAIL(1'b0)) dut_a (
        .clk(clk), .rst_n(rst_n), .start_B_all_frame_ER(start_drv && (sel == 2'd0)),
        .sf_if(if_a), .total_leaked_info(tl_a), .total_error_count(te_a),
        .failed_frame_count(ffc_a), .all_frame_fail(aff_a), .finish_all_frame_ER(fin_a),
        .busy(busy_a), .B_all_frame_state(st_a));

    b_all_frame_er_ctrl #(.MAX_FRAME_ROUND(3), .FRAME_ROUND_WIDTH(3), .LEAKED_WIDTH(16),
                          .ERRCNT_WIDTH(16), .TOTAL_WIDTH(24), .ABORT_ON_FAIL(1'b1)) dut_b (
        .clk(clk), .rst_n(rst_n), .start_B_all_frame_ER(start_drv && (sel == 2'd1)),
        .sf_if(if_b), .total_leaked_info(tl_b), .total_error_count(te_b),
        .failed_frame_count(ffc_b), .all_frame_fail(aff_b), .finish_all_frame_ER(fin_b),
        .busy(busy_b), .B_all_frame_state(st_b));

    b_all_frame_er_ctrl #(.MAX_FRAME_ROUND(3), .FRAME_ROUND_WIDTH(3), .LEAKED_WIDTH(16),
                          .ERRCNT_WIDTH(16), .TOTAL_WIDTH(8), .ABORT_ON_FAIL(1'b0)) dut_c (
        .clk(clk), .rst_n(rst_n), .start_B_all_frame_ER(start_drv && (sel == 2'd2)),
        .sf_if(if_c), .total_leaked_info(tl_c), .total_error_count(te_c),
        .failed_frame_count(ffc_c), .all_frame_fail(aff_c), .finish_all_frame_ER(fin_c),
        .busy(busy_c), .B_all_frame_state(st_c));

    // Outputs of the selected controller.
    logic        o_start, o_aff, o_fin, o_busy;
    logic [2:0]  o_round;
    logic [23:0] o_tl, o_te;
    logic [3:0]  o_ffc, o_state;

    always_comb begin
        o_start = if_a.start_single_frame_ER; o_round = if_a.frame_round;
        o_tl = tl_a; o_te = te_a; o_ffc = ffc_a; o_aff = aff_a;
        o_fin = fin_a; o_busy = busy_a; o_state = st_a;
        if (sel == 2'd1) begin
            o_start = if_b.start_single_frame_ER; o_round = if_b.frame_round;
            o_tl = tl_b; o_te = te_b; o_ffc = ffc_b; o_aff = aff_b;
            o_fin = fin_b; o_busy = busy_b; o_state = st_b;
        end else if (sel == 2'd2) begin
            o_start = if_c.start_single_frame_ER; o_round = if_c.frame_round;
            o_tl = {16'd0, tl_c}; o_te = {16'd0, te_c}; o_ffc = ffc_c; o_aff = aff_c;
            o_fin = fin_c; o_busy = busy_c; o_state = st_c;
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (o_start) n_start <= n_start + 1;
        if (o_fin)   n_fin   <= n_fin + 1;
    end

    task automatic tick();
        @(negedge clk);
    endtask

    // Run one all-frame sequence: n_exp frames are expected to be started;
    // frame fail_frame reports fail with valid coincident with finish.
    task automatic run_af(input int n_exp, input logic [15:0] lk, input logic [15:0] er,
                          input int fail_frame, input string tag);
        int s, p, t, w, base_start, base_fin;
        base_start = n_start;
        base_fin   = n_fin;
        leaked_drv = lk;
        err_drv    = er;
        start_drv  = 1'b1;
        s = cyc;
        tick();
        start_drv  = 1'b0;
        t = -1;
        for (int f = 0; f < n_exp; f++) begin
            w = 0;
            while (!o_start && w < 40) begin tick(); w++; end
            n_cmp++;
            if (o_start !== 1'b1) begin
                $display("FAIL %s start_timeout frame %0d: got no start pulse, required one", tag, f);
                n_bad++;
                return;
            end
            p = cyc;
            n_cmp++;
            if (p !== ((f == 0) ? s + 2 : t + 2)) begin
                $display("FAIL %s start_cycle frame %0d: got %0d required %0d", tag, f, p,
                         (f == 0) ? s + 2 : t + 2);
                n_bad++;
            end
            n_cmp++;
            if (o_round !== 3'(f)) begin
                $display("FAIL %s frame_round: got %0d required %0d", tag, o_round, f);
                n_bad++;
            end
            tick();
            if (f != fail_frame) begin
                valid_drv = 1'b1;
                tick();
                valid_drv = 1'b0;
            end else begin
                valid_drv = 1'b1;
                fail_drv  = 1'b1;
            end
            finish_drv = 1'b1;
            t = cyc;
            tick();
            finish_drv = 1'b0;
            valid_drv  = 1'b0;
            fail_drv   = 1'b0;
        end
        w = 0;
        while (!o_fin && w < 20) begin tick(); w++; end
        n_cmp++;
        if (o_fin !== 1'b1) begin
            $display("FAIL %s finish_timeout: got no finish_all_frame_ER, required one", tag);
            n_bad++;
            return;
        end
        n_cmp++;
        if (cyc !== t + 2) begin
            $display("FAIL %s finish_latency: got cycle %0d required %0d", tag, cyc, t + 2);
            n_bad++;
        end
        n_cmp++;
        if (o_round !== 3'd0) begin
            $display("FAIL %s round_at_finish: got %0d required 0", tag, o_round);
            n_bad++;
        end
        tick();
        n_cmp++;
        if (o_state !== ST_IDLE) begin
            $display("FAIL %s idle_after_finish: got %0d required %0d", tag, o_state, ST_IDLE);
            n_bad++;
        end
        n_cmp++;
        if (n_start - base_start !== n_exp) begin
            $display("FAIL %s start_pulses: got %0d required %0d", tag, n_start - base_start, n_exp);
            n_bad++;
        end
        n_cmp++;
        if (n_fin - base_fin !== 1) begin
            $display("FAIL %s finish_pulses: got %0d required 1", tag, n_fin - base_fin);
            n_bad++;
        end
    endtask

    task automatic check_totals(input string tag, input int tl, input int te, input int ffc,
                                input logic aff);
        n_cmp++;
        if (o_tl !== 24'(tl)) begin
            $display("FAIL %s total_leaked: got %0d required %0d", tag, o_tl, tl); n_bad++;
        end
        n_cmp++;
        if (o_te !== 24'(te)) begin
            $display("FAIL %s total_error: got %0d required %0d", tag, o_te, te); n_bad++;
        end
        n_cmp++;
        if (o_ffc !== 4'(ffc)) begin
            $display("FAIL %s failed_frames: got %0d required %0d", tag, o_ffc, ffc); n_bad++;
        end
        n_cmp++;
        if (o_aff !== aff) begin
            $display("FAIL %s all_frame_fail: got %0b required %0b", tag, o_aff, aff); n_bad++;
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            sel = 2'(i);
            #1;
            n_cmp++;
            if ({o_state, o_round, o_start, o_fin, o_busy} !== 11'd0) begin
                $display("FAIL reset_ctrl dut%0d: got state=%0d round=%0d start=%0b fin=%0b busy=%0b required all 0",
                         i, o_state, o_round, o_start, o_fin, o_busy);
                n_bad++;
            end
            check_totals("reset", 0, 0, 0, 1'b0);
        end
        sel = 2'd0;
        tick();
    endtask

    task automatic test_clean_run();
        sel = 2'd0; tick();
        run_af(4, 16'd100, 16'd5, -1, "clean");
        check_totals("clean", 400, 20, 0, 1'b0);
    endtask

    task automatic test_fail_no_abort();
        sel = 2'd0; tick();
        run_af(4, 16'd100, 16'd5, 1, "fail_noabort");
        check_totals("fail_noabort", 400, 20, 1, 1'b1);
    endtask

    task automatic test_fail_abort();
        int base;
        sel = 2'd1; tick();
        run_af(2, 16'd100, 16'd5, 1, "fail_abort");
        check_totals("fail_abort", 200, 10, 1, 1'b1);
        base = n_start;
        repeat (10) tick();
        n_cmp++;
        if (n_start !== base) begin
            $display("FAIL abort_no_more_starts: got %0d extra required 0", n_start - base);
            n_bad++;
        end
        check_totals("abort_hold", 200, 10, 1, 1'b1);
    endtask

    task automatic test_saturate();
        sel = 2'd2; tick();
        run_af(4, 16'd200, 16'd5, -1, "saturate");
        check_totals("saturate", 255, 20, 0, 1'b0);
        repeat (3) tick();
        check_totals("sat_hold", 255, 20, 0, 1'b0);
    endtask

    task automatic test_ignored_idle();
        int base;
        sel = 2'd0; tick();
        base = n_start;
        leaked_drv = 16'd7; err_drv = 16'd3;
        finish_drv = 1'b1; valid_drv = 1'b1; fail_drv = 1'b1;
        tick();
        finish_drv = 1'b0; valid_drv = 1'b0; fail_drv = 1'b0;
        tick();
        n_cmp++;
        if (o_state !== ST_IDLE || o_busy !== 1'b0 || n_start !== base) begin
            $display("FAIL idle_ignore: got state=%0d busy=%0b starts=%0d required state=0 busy=0 starts=0",
                     o_state, o_busy, n_start - base);
            n_bad++;
        end
        check_totals("idle_ignore", 400, 20, 1, 1'b1);
    endtask

    task automatic test_busy_start_and_reset();
        int base, base_fin, w;
        sel = 2'd0; tick();
        leaked_drv = 16'd100; err_drv = 16'd5;
        start_drv = 1'b1; tick(); start_drv = 1'b0;
        w = 0;
        while (!o_start && w < 10) begin tick(); w++; end
        tick();
        n_cmp++;
        if (o_state !== ST_SF_ER_BUSY) begin
            $display("FAIL busy_reached: got state %0d required %0d", o_state, ST_SF_ER_BUSY);
            n_bad++;
        end
        base = n_start;
        base_fin = n_fin;
        start_drv = 1'b1; valid_drv = 1'b1; tick(); start_drv = 1'b0; valid_drv = 1'b0;
        n_cmp++;
        if (o_state !== ST_SF_ER_BUSY || n_start !== base) begin
            $display("FAIL busy_start_ignored: got state=%0d extra_starts=%0d required state=3 extra_starts=0",
                     o_state, n_start - base);
            n_bad++;
        end
        check_totals("valid_latency", 100, 5, 0, 1'b0);
        rst_n = 1'b0; tick();
        n_cmp++;
        if ({o_state, o_round, o_start, o_fin, o_busy} !== 11'd0) begin
            $display("FAIL midrun_reset: got state=%0d round=%0d start=%0b fin=%0b busy=%0b required all 0",
                     o_state, o_round, o_start, o_fin, o_busy);
            n_bad++;
        end
        check_totals("midrun_reset", 0, 0, 0, 1'b0);
        rst_n = 1'b1;
        repeat (6) tick();
        n_cmp++;
        if (n_fin !== base_fin || o_state !== ST_IDLE) begin
            $display("FAIL reset_no_finish: got finishes=%0d state=%0d required 0 and 0",
                     n_fin - base_fin, o_state);
            n_bad++;
        end
    endtask

    initial begin
        rst_n = 1'b0; sel = 2'd0;
        start_drv = 1'b0; finish_drv = 1'b0; valid_drv = 1'b0; fail_drv = 1'b0;
        leaked_drv = '0; err_drv = '0;
        repeat (3) tick();
        test_reset();
        rst_n = 1'b1;
        tick();
        test_clean_run();
        test_fail_no_abort();
        test_fail_abort();
        test_saturate();
        test_ignored_idle();
        test_busy_start_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
